// File: rtl/uart_cmd_responder_if.sv
// UART FIFO-side bus for the command responder: receive-FIFO head and pop,
// transmit-FIFO push and back-pressure.
interface uart_cmd_responder_if;
  logic [7:0] r_data;
  logic       rx_empty;
  logic       rd_uart;
  logic [7:0] w_data;
  logic       wr_uart;
  logic       tx_full;

  // responder side: pops RX, pushes TX
  modport master (input r_data, rx_empty, tx_full, output rd_uart, w_data, wr_uart);
  // FIFO side
  modport slave  (output r_data, rx_empty, tx_full, input rd_uart, w_data, wr_uart);
endinterface

// File: rtl/uart_cmd_responder.sv
// Microwave command parser: 'S' start, 'P' stop, 'T'dd set cook time.
// Each command answers one byte ('K' ok, '?' error) on the TX FIFO.
module uart_cmd_responder #(
  parameter int DIGIT_TIMEOUT = 1000000
) (
  input  logic                         clk,
  input  logic                         rst,
  uart_cmd_responder_if.master         bus,
  output logic                         start_pulse,
  output logic                         stop_pulse,
  output logic                         time_load,
  output logic [6:0]                   time_sec
);
  localparam int CW = (DIGIT_TIMEOUT > 1) ? $clog2(DIGIT_TIMEOUT) : 1;
  localparam logic [7:0] CH_K = 8'h4B, CH_Q = 8'h3F;

  typedef enum logic [1:0] {IDLE, GET_D1, GET_D0, RESP} state_t;

  state_t        state_q, state_nxt;
  logic [7:0]    resp_q, resp_nxt;
  logic [3:0]    tens_q, tens_nxt;
  logic [6:0]    time_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          start_nxt, stop_nxt, load_nxt;
  logic          is_digit, timed_out;

  assign is_digit  = (bus.r_data >= 8'h30) && (bus.r_data <= 8'h39);
  assign timed_out = bus.rx_empty && (cnt_q == CW'(DIGIT_TIMEOUT - 1));

  // state, response, digit and pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      resp_q      <= 8'h00;
      tens_q      <= 4'd0;
      time_sec    <= 7'd0;
      cnt_q       <= '0;
      start_pulse <= 1'b0;
      stop_pulse  <= 1'b0;
      time_load   <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      resp_q      <= resp_nxt;
      tens_q      <= tens_nxt;
      time_sec    <= time_nxt;
      cnt_q       <= cnt_nxt;
      start_pulse <= start_nxt;
      stop_pulse  <= stop_nxt;
      time_load   <= load_nxt;
    end
  end

  // next state; a byte present in the timeout cycle takes priority over the timeout
  always_comb begin
    state_nxt = state_q;
    resp_nxt  = resp_q;
    tens_nxt  = tens_q;
    time_nxt  = time_sec;
    cnt_nxt   = cnt_q;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    load_nxt  = 1'b0;
    case (state_q)
      IDLE: if (!bus.rx_empty) begin
        case (bus.r_data)
          8'h53:   begin state_nxt = RESP; resp_nxt = CH_K; start_nxt = 1'b1; end
          8'h50:   begin state_nxt = RESP; resp_nxt = CH_K; stop_nxt  = 1'b1; end
          8'h54:   begin state_nxt = GET_D1; cnt_nxt = '0; end
          default: begin state_nxt = RESP; resp_nxt = CH_Q; end
        endcase
      end
      GET_D1, GET_D0: begin
        if (!bus.rx_empty) begin
          if (!is_digit) begin
            state_nxt = RESP;
            resp_nxt  = CH_Q;
          end else if (state_q == GET_D1) begin
            tens_nxt  = bus.r_data[3:0];
            state_nxt = GET_D0;
            cnt_nxt   = '0;
          end else begin
            time_nxt  = 7'(tens_q) * 7'd10 + 7'(bus.r_data[3:0]);
            load_nxt  = 1'b1;
            state_nxt = RESP;
            resp_nxt  = CH_K;
          end
        end else if (timed_out) begin
          state_nxt = RESP;
          resp_nxt  = CH_Q;
        end else begin
          cnt_nxt = cnt_q + 1'b1;
        end
      end
      RESP: if (!bus.tx_full) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO strobes; forced quiet while reset is held
  always_comb begin
    bus.rd_uart = !rst && (state_q != RESP) && !bus.rx_empty;
    bus.wr_uart = !rst && (state_q == RESP) && !bus.tx_full;
    bus.w_data  = rst ? 8'h00 : resp_q;
  end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with a queue-backed RX FIFO model.
module tb_uart_cmd_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_pulse, stop_pulse, time_load;
  logic [6:0] time_sec;

  uart_cmd_responder_if bus ();

  uart_cmd_responder #(.DIGIT_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.master),
    .start_pulse(start_pulse), .stop_pulse(stop_pulse),
    .time_load(time_load), .time_sec(time_sec)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  int n_rd, n_start, n_stop, n_load, n_both;
  logic l_rd, l_wr, l_start, l_stop, l_load;
  logic [7:0] l_wd;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic drive();
    bus.rx_empty = (rxq.size() == 0);
    bus.r_data   = (rxq.size() != 0) ? rxq[0] : 8'h00;
  endtask

  task automatic clr();
    n_rd = 0; n_start = 0; n_stop = 0; n_load = 0;
    txq.delete();
  endtask

  // sample on the falling edge, then advance past the rising edge and update the FIFO model
  task automatic tick();
    @(negedge clk);
    l_rd = bus.rd_uart; l_wr = bus.wr_uart; l_wd = bus.w_data;
    l_start = start_pulse; l_stop = stop_pulse; l_load = time_load;
    if (l_rd && l_wr) n_both++;
    if (l_rd) n_rd++;
    if (l_wr) txq.push_back(l_wd);
    if (l_start) n_start++;
    if (l_stop) n_stop++;
    if (l_load) n_load++;
    @(posedge clk); #1;
    if (l_rd && rxq.size() != 0) void'(rxq.pop_front());
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    rxq.push_back(a); rxq.push_back(b); rxq.push_back(c); drive();
  endtask

  initial begin
    int k;
    n_both = 0;
    rst = 1'b1; bus.tx_full = 1'b0;
    rxq.push_back(8'h53); drive(); clr();

    // reset holds everything quiet even with a byte waiting
    tick();
    chk("rst_rd", l_rd, 0);
    chk("rst_wr", l_wr, 0);
    chk("rst_wdata", l_wd, 8'h00);
    chk("rst_time", time_sec, 0);
    chk("rst_pulses", {l_start, l_stop, l_load}, 0);

    // 'S' cycle-exact
    rst = 1'b0;
    tick();
    chk("s_pop", {l_rd, l_wr}, 2'b10);
    tick();
    chk("s_start", l_start, 1);
    chk("s_wr", l_wr, 1);
    chk("s_wdata", l_wd, 8'h4B);
    chk("s_nopop", l_rd, 0);
    tick();
    chk("s_idle", {l_wr, l_start}, 0);

    // T45 then T99
    clr(); send3(8'h54, 8'h34, 8'h35); run(10);
    chk("t45_time", time_sec, 45);
    chk("t45_load", n_load, 1);
    chk("t45_ntx", txq.size(), 1);
    chk("t45_resp", (txq.size() > 0) ? txq[0] : 0, 8'h4B);
    chk("t45_nostart", n_start + n_stop, 0);
    clr(); send3(8'h54, 8'h39, 8'h39); run(10);
    chk("t99_time", time_sec, 99);
    chk("t99_load", n_load, 1);

    // non-digit in GET_D0, unknown byte in IDLE
    clr(); send3(8'h54, 8'h34, 8'h78); run(10);
    chk("t4x_resp", (txq.size() > 0) ? txq[0] : 0, 8'h3F);
    chk("t4x_time", time_sec, 99);
    chk("t4x_load", n_load, 0);
    clr(); rxq.push_back(8'h41); drive(); run(5);
    chk("a_ntx", txq.size(), 1);
    chk("a_resp", (txq.size() > 0) ? txq[0] : 0, 8'h3F);

    // timeout: write of '?' lands 17 ticks after the pop tick
    clr(); rxq.push_back(8'h54); drive();
    tick();
    chk("to_pop", l_rd, 1);
    k = 0;
    do begin tick(); k++; end while (!l_wr && k < 40);
    chk("to_cycles", k, 17);
    chk("to_resp", l_wd, 8'h3F);
    run(2);

    // digit arriving in the last counted cycle beats the timeout
    clr(); rxq.push_back(8'h54); drive();
    tick(); run(15);
    rxq.push_back(8'h35); rxq.push_back(8'h37); drive();
    run(8);
    chk("late_ntx", txq.size(), 1);
    chk("late_resp", (txq.size() > 0) ? txq[0] : 0, 8'h4B);
    chk("late_time", time_sec, 57);

    // tx_full stall after 'P', with another command waiting
    clr(); bus.tx_full = 1'b1; rxq.push_back(8'h50); drive();
    tick();
    n_rd = 0; rxq.push_back(8'h53); drive();
    run(10);
    chk("stall_rd", n_rd, 0);
    chk("stall_wr", txq.size(), 0);
    chk("stall_stop", n_stop, 1);
    bus.tx_full = 1'b0; run(8);
    chk("stall_ntx", txq.size(), 2);
    chk("stall_stop_once", n_stop, 1);
    chk("stall_next_s", n_start, 1);

    // reset in GET_D0
    clr(); rxq.push_back(8'h54); rxq.push_back(8'h34); drive();
    run(3);
    rst = 1'b1; tick(); rst = 1'b0; run(5);
    chk("rd0_ntx", txq.size(), 0);
    chk("rd0_time", time_sec, 0);
    chk("rd0_load", n_load, 0);
    clr(); rxq.push_back(8'h53); drive(); run(5);
    chk("rd0_s_resp", (txq.size() == 1) ? txq[0] : 0, 8'h4B);
    chk("rd0_s_start", n_start, 1);

    // reset in stalled RESP
    clr(); bus.tx_full = 1'b1; rxq.push_back(8'h50); drive();
    run(3);
    rst = 1'b1; tick(); rst = 1'b0; bus.tx_full = 1'b0; run(5);
    chk("rresp_ntx", txq.size(), 0);
    clr(); rxq.push_back(8'h53); drive(); run(5);
    chk("rresp_s_resp", (txq.size() == 1) ? txq[0] : 0, 8'h4B);

    chk("never_rd_wr", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
